// File: rtl/axi_ctrl_pkg.sv
// Shared definitions for the AXI-style master controller: FSM encoding and
// default widths/timeout.
package axi_ctrl_pkg;

    localparam int unsigned DEF_ADDR_W  = 4;
    localparam int unsigned DEF_DATA_W  = 4;
    localparam int unsigned DEF_TIMEOUT = 16;

    typedef enum logic [1:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR
    } ctrl_state_t;

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for an asynchronous button level followed by a
// rising-edge detector that emits a one-cycle command pulse.
module btn_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic rise
);

    logic       sync1, sync2, prev;
    logic [1:0] live;
    logic       armed;

    // armed only after the synchronizer holds real samples and has seen the
    // button low, so a level held through reset release is not an edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
            live  <= '0;
            armed <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            prev  <= sync2;
            live  <= {live[0], 1'b1};
            if (live[1] && !sync2)
                armed <= 1'b1;
        end
    end

    assign rise = sync2 && !prev && armed;

endmodule

// File: rtl/axi_master_ctrl.sv
// Button-driven single-beat read/write master with per-phase timeout,
// sticky error flag and one-cycle done pulse.
module axi_master_ctrl
    import axi_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEF_TIMEOUT,
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_rd,
    input  logic              btn_wr,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] wdata_in,
    output logic              ms_arvalid,
    output logic [ADDR_W-1:0] ms_araddr,
    input  logic              sm_arready,
    input  logic              sm_rvalid,
    input  logic [DATA_W-1:0] sm_rdata,
    output logic              ms_rready,
    output logic              ms_awvalid,
    output logic [ADDR_W-1:0] ms_awaddr,
    input  logic              sm_awready,
    output logic              ms_wvalid,
    output logic [DATA_W-1:0] ms_wdata,
    input  logic              sm_wready,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    ctrl_state_t       state, next_state;
    logic              rd_rise, wr_rise;
    logic              accept, complete, abort;
    logic              aw_hs, w_hs, aw_done, w_done;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    btn_sync_edge u_rd_sync (.clk(clk), .reset(reset), .btn(btn_rd), .rise(rd_rise));
    btn_sync_edge u_wr_sync (.clk(clk), .reset(reset), .btn(btn_wr), .rise(wr_rise));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        complete   = 1'b0;
        abort      = 1'b0;
        busy       = (state != IDLE);
        ms_arvalid = (state == RD_ADDR);
        ms_rready  = (state == RD_DATA);
        ms_awvalid = (state == WR) && !aw_done;
        ms_wvalid  = (state == WR) && !w_done;
        aw_hs      = ms_awvalid && sm_awready;
        w_hs       = ms_wvalid && sm_wready;
        case (state)
            IDLE: begin
                // read wins a same-cycle tie; the write edge is simply dropped
                if (rd_rise) begin
                    next_state = RD_ADDR;
                    accept     = 1'b1;
                end else if (wr_rise) begin
                    next_state = WR;
                    accept     = 1'b1;
                end
            end
            RD_ADDR: begin
                if (sm_arready) begin
                    next_state = RD_DATA;
                end else if (cnt == CNT_LAST) begin
                    next_state = IDLE;
                    abort      = 1'b1;
                end
            end
            RD_DATA: begin
                if (sm_rvalid) begin
                    next_state = IDLE;
                    complete   = 1'b1;
                end else if (cnt == CNT_LAST) begin
                    next_state = IDLE;
                    abort      = 1'b1;
                end
            end
            WR: begin
                if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                    next_state = IDLE;
                    complete   = 1'b1;
                end else if (cnt == CNT_LAST) begin
                    next_state = IDLE;
                    abort      = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            rd_data <= '0;
            cnt     <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= complete;
            if (accept) begin
                addr_q  <= addr_in;
                wdata_q <= wdata_in;
                err     <= 1'b0;
            end else if (abort) begin
                err <= 1'b1;
            end
            if (state == RD_DATA && complete)
                rd_data <= sm_rdata;
            if (next_state != state || state == IDLE)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
            aw_done <= (next_state == WR) && (aw_done || aw_hs);
            w_done  <= (next_state == WR) && (w_done || w_hs);
        end
    end

    assign ms_araddr = addr_q;
    assign ms_awaddr = addr_q;
    assign ms_wdata  = wdata_q;

endmodule

// File: tb/tb_axi_master_ctrl.sv
// Scoreboard bench for axi_master_ctrl: stimulus pushes expected outcomes,
// a negedge monitor pops and compares them on each done pulse or err rise.
module tb_axi_master_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_rd, btn_wr;
    logic [3:0] addr_in, wdata_in;
    logic       ms_arvalid, sm_arready, sm_rvalid, ms_rready;
    logic       ms_awvalid, sm_awready, ms_wvalid, sm_wready;
    logic [3:0] ms_araddr, sm_rdata, ms_awaddr, ms_wdata, rd_data;
    logic       busy, done, err;

    always #5 clk = ~clk;

    axi_master_ctrl #(.TIMEOUT(16), .ADDR_W(4), .DATA_W(4)) dut (
        .clk(clk), .reset(reset), .btn_rd(btn_rd), .btn_wr(btn_wr),
        .addr_in(addr_in), .wdata_in(wdata_in),
        .ms_arvalid(ms_arvalid), .ms_araddr(ms_araddr), .sm_arready(sm_arready),
        .sm_rvalid(sm_rvalid), .sm_rdata(sm_rdata), .ms_rready(ms_rready),
        .ms_awvalid(ms_awvalid), .ms_awaddr(ms_awaddr), .sm_awready(sm_awready),
        .ms_wvalid(ms_wvalid), .ms_wdata(ms_wdata), .sm_wready(sm_wready),
        .rd_data(rd_data), .busy(busy), .done(done), .err(err)
    );

    typedef struct {
        bit         is_err;
        bit         is_wr;
        logic [3:0] addr;
        logic [3:0] data;
        logic [3:0] rd;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push(input bit is_err, input bit is_wr, input logic [3:0] a,
                        input logic [3:0] d, input logic [3:0] rd);
        exp_t e;
        e.is_err = is_err;
        e.is_wr  = is_wr;
        e.addr   = a;
        e.data   = d;
        e.rd     = rd;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input bit rd, input bit wr);
        btn_rd = rd;
        btn_wr = wr;
        repeat (3) tick();
        btn_rd = 1'b0;
        btn_wr = 1'b0;
    endtask

    function automatic logic vsel(input int w);
        case (w)
            0:       return ms_arvalid;
            1:       return ms_awvalid;
            default: return ms_rready;
        endcase
    endfunction

    task automatic wait_hi(input string name, input int w);
        int t = 0;
        while (!vsel(w) && t < 40) begin
            tick();
            t++;
        end
        chk(name, vsel(w), 1);
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while (busy && t < 60) begin
            tick();
            t++;
        end
        chk(name, busy, 0);
    endtask

    task automatic serve_read(input int ar_dly, input logic [3:0] data);
        wait_hi("arvalid_seen", 0);
        repeat (ar_dly) tick();
        sm_arready = 1'b1;
        tick();
        sm_arready = 1'b0;
        sm_rvalid  = 1'b1;
        sm_rdata   = data;
        tick();
        sm_rvalid  = 1'b0;
    endtask

    task automatic check_zero(input string name);
        chk({name, "_ctrl"}, {ms_arvalid, ms_rready, ms_awvalid, ms_wvalid, busy, done, err}, 0);
        chk({name, "_rd_data"}, rd_data, 0);
        chk({name, "_regs"}, {ms_araddr, ms_awaddr, ms_wdata}, 0);
    endtask

    // Monitor: tracks handshakes and compares each completion/abort event.
    logic [3:0] cur_addr, cur_data;
    bit         seen_w, done_prev, err_prev;

    initial begin
        exp_t e;
        cur_addr  = '0;
        cur_data  = '0;
        seen_w    = 1'b0;
        done_prev = 1'b0;
        err_prev  = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                seen_w    = 1'b0;
                done_prev = 1'b0;
                err_prev  = 1'b0;
            end else begin
                if (ms_awvalid || ms_wvalid) seen_w = 1'b1;
                if (ms_arvalid && sm_arready) cur_addr = ms_araddr;
                if (ms_awvalid && sm_awready) cur_addr = ms_awaddr;
                if (ms_wvalid && sm_wready)   cur_data = ms_wdata;
                if (done) chk("done_one_cycle", done_prev, 0);
                if (done || (err && !err_prev)) begin
                    chk("event_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("event_kind", {done, err}, e.is_err ? 2'b01 : 2'b10);
                        chk("rd_data", rd_data, e.rd);
                        if (!e.is_err) begin
                            chk("txn_addr", cur_addr, e.addr);
                            if (e.is_wr) chk("txn_wdata", cur_data, e.data);
                            else         chk("no_write_activity", seen_w, 0);
                        end
                    end
                    seen_w = 1'b0;
                end
                done_prev = done;
                err_prev  = err;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, errors %0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        reset = 1'b0; btn_rd = 1'b0; btn_wr = 1'b0;
        addr_in = '0; wdata_in = '0;
        sm_arready = 1'b0; sm_rvalid = 1'b0; sm_rdata = '0;
        sm_awready = 1'b0; sm_wready = 1'b0;
        repeat (3) tick();
        check_zero("reset");
        reset = 1'b1;
        repeat (5) tick();

        // Read: accept latency, stable address, rd_data = A
        addr_in = 4'h3;
        push(0, 0, 4'h3, 4'h0, 4'hA);
        btn_rd = 1'b1;
        tick(); tick();
        chk("arvalid_before_accept", ms_arvalid, 0);
        tick();
        chk("arvalid_after_accept", ms_arvalid, 1);
        chk("araddr", ms_araddr, 4'h3);
        btn_rd  = 1'b0;
        addr_in = 4'hF;
        tick();
        chk("araddr_stable", ms_araddr, 4'h3);
        serve_read(0, 4'hA);
        wait_idle("read_idle");
        chk("read_err", err, 0);

        // Write: wready before awready
        addr_in = 4'h5; wdata_in = 4'hC;
        push(0, 1, 4'h5, 4'hC, 4'hA);
        press(0, 1);
        wait_hi("awvalid_seen", 1);
        chk("wvalid_with_awvalid", ms_wvalid, 1);
        sm_wready = 1'b1;
        tick();
        sm_wready = 1'b0;
        chk("wvalid_dropped", ms_wvalid, 0);
        chk("awvalid_held", ms_awvalid, 1);
        tick(); tick();
        chk("awvalid_still_held", {ms_awvalid, busy}, 2'b11);
        sm_awready = 1'b1;
        tick();
        sm_awready = 1'b0;
        chk("write_done", {done, busy}, 2'b10);
        tick();
        chk("write_done_cleared", done, 0);

        // Simultaneous buttons: read only
        addr_in = 4'h7;
        push(0, 0, 4'h7, 4'h0, 4'h6);
        press(1, 1);
        serve_read(0, 4'h6);
        wait_idle("simul_idle");

        // Silent slave: timeout after 16 cycles, then err cleared by next command
        addr_in = 4'h9;
        push(1, 0, 4'h0, 4'h0, 4'h6);
        press(1, 0);
        wait_hi("timeout_arvalid", 0);
        n = 0;
        while (ms_arvalid && n < 40) begin
            tick();
            n++;
        end
        chk("arvalid_cycles", n, 16);
        chk("timeout_flags", {err, done, busy}, 3'b100);
        chk("timeout_rd_data", rd_data, 4'h6);
        repeat (5) tick();
        chk("err_sticky", err, 1);
        addr_in = 4'h2;
        push(0, 0, 4'h2, 4'h0, 4'h5);
        press(1, 0);
        chk("err_cleared", err, 0);
        serve_read(0, 4'h5);
        wait_idle("after_timeout_idle");

        // Write press during RD_DATA is discarded
        addr_in = 4'h4;
        push(0, 0, 4'h4, 4'h0, 4'h9);
        press(1, 0);
        wait_hi("rd5_arvalid", 0);
        sm_arready = 1'b1;
        tick();
        sm_arready = 1'b0;
        chk("rready_in_rd_data", ms_rready, 1);
        press(0, 1);
        tick();
        sm_rvalid = 1'b1; sm_rdata = 4'h9;
        tick();
        sm_rvalid = 1'b0;
        n = 0;
        repeat (20) begin
            tick();
            if (busy || ms_awvalid || ms_wvalid) n++;
        end
        chk("no_write_after_read", n, 0);

        // Reset during WR with both valids high
        addr_in = 4'hE; wdata_in = 4'h1;
        press(0, 1);
        wait_hi("rst_awvalid", 1);
        chk("rst_wvalid", ms_wvalid, 1);
        #2 reset = 1'b0;
        #1 check_zero("reset_mid_wr");
        tick(); tick();
        reset = 1'b1;
        repeat (5) tick();
        chk("idle_after_reset", {busy, ms_awvalid, ms_wvalid, done, err}, 0);

        // Button held through reset release issues no command
        reset = 1'b0;
        btn_rd = 1'b1;
        addr_in = 4'h6;
        tick(); tick();
        reset = 1'b1;
        n = 0;
        repeat (10) begin
            tick();
            if (busy) n++;
        end
        chk("held_btn_no_cmd", n, 0);
        btn_rd = 1'b0;
        repeat (3) tick();
        push(0, 0, 4'h6, 4'h0, 4'h3);
        press(1, 0);
        serve_read(0, 4'h3);
        wait_idle("repress_idle");

        repeat (5) tick();
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
